handshake_fifo: RTL and testbench

Parametrised, single-clock successor to the one-entry handshake register. It buffers up to DEPTH words of WIDTH bits between a req/ack producer and a valid/ready consumer. It sits between pipeline stages of the async CPU where back-pressure must not drop data. It also reports occupancy, almost-full and a sticky overflow-attempt flag for debug.

---
 rtl/hs_pkg.sv | 19 +
 rtl/hs_fifo_mem.sv | 32 +++
 rtl/handshake_fifo.sv | 124 ++++++++++++
 tb/tb_handshake_fifo.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hs_pkg
//  Description : Shared constants, types and helpers for the handshake FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package hs_pkg;

    localparam int HS_DATA_W = 42;

    typedef logic [HS_DATA_W-1:0] hs_word_t;

    // Width needed to hold the values 0..d inclusive.
    function automatic int clog2_p1(input int d);
        return $clog2(d + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hs_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : hs_fifo_mem
//  Description : DEPTH x WIDTH register array, one write port, async read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module hs_fifo_mem
    import hs_pkg::*;
#(
    parameter int WIDTH = HS_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/handshake_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_fifo
//  Description : Single-clock req/ack to valid/ready FIFO with occupancy,
//                almost-full and sticky overflow-attempt reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module handshake_fifo
    import hs_pkg::*;
#(
    parameter int WIDTH     = HS_DATA_W,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req,
    output logic                         ack,
    input  logic [WIDTH-1:0]             data_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             data_out,
    output logic [clog2_p1(DEPTH)-1:0]   count,
    output logic                         almost_full,
    output logic                         ovf_sticky
);

    localparam int c_CNT_W = clog2_p1(DEPTH);
    localparam int c_PTR_W = $clog2(DEPTH);

    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF_CNT   = c_CNT_W'(AF_THRESH);
    localparam logic [c_CNT_W-1:0] c_ONE_CNT  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);

    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_data_out;
    logic               r_ovf;

    logic               w_push;
    logic               w_pop;
    logic [c_PTR_W-1:0] w_wptr_inc;
    logic [c_PTR_W-1:0] w_rptr_inc;
    logic [WIDTH-1:0]   w_next_head;
    logic [WIDTH-1:0]   w_data_nxt;
    logic [c_CNT_W-1:0] w_count_nxt;

    assign ack         = (r_count != c_FULL_CNT);
    assign out_valid   = (r_count != '0);
    assign almost_full = (r_count >= c_AF_CNT);
    assign count       = r_count;
    assign data_out    = r_data_out;
    assign ovf_sticky  = r_ovf;

    assign w_push = req && ack;
    assign w_pop  = out_valid && out_ready;

    assign w_wptr_inc = (r_wptr == c_LAST_PTR) ? '0 : r_wptr + 1'b1;
    assign w_rptr_inc = (r_rptr == c_LAST_PTR) ? '0 : r_rptr + 1'b1;

    // Read port looks one entry ahead so the head register can reload on a pop.
    hs_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_push),
        .wr_addr (r_wptr),
        .wr_data (data_in),
        .rd_addr (w_rptr_inc),
        .rd_data (w_next_head)
    );

    // Head register: bypass data_in when the incoming word becomes the new head.
    always_comb begin
        w_data_nxt = r_data_out;
        if (w_pop) begin
            if (r_count == c_ONE_CNT) begin
                if (w_push) begin
                    w_data_nxt = data_in;
                end
            end else begin
                w_data_nxt = w_next_head;
            end
        end else if ((r_count == '0) && w_push) begin
            w_data_nxt = data_in;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_data_out <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= w_wptr_inc;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_inc;
            end
            r_count    <= w_count_nxt;
            r_data_out <= w_data_nxt;
            if (req && !ack) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_handshake_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_handshake_fifo
//  Description : Directed self-checking bench for handshake_fifo (DEPTH 4 and 3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_a = 1'b0;
    logic        rdy_a = 1'b0;
    logic [41:0] din_a = '0;
    logic        ack_a, vld_a, af_a, ovf_a;
    logic [41:0] dout_a;
    logic [2:0]  cnt_a;

    logic        req_b = 1'b0;
    logic        rdy_b = 1'b0;
    logic [41:0] din_b = '0;
    logic        ack_b, vld_b, af_b, ovf_b;
    logic [41:0] dout_b;
    logic [1:0]  cnt_b;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    handshake_fifo #(.WIDTH(42), .DEPTH(4), .AF_THRESH(3)) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_a),
        .ack         (ack_a),
        .data_in     (din_a),
        .out_valid   (vld_a),
        .out_ready   (rdy_a),
        .data_out    (dout_a),
        .count       (cnt_a),
        .almost_full (af_a),
        .ovf_sticky  (ovf_a)
    );

    handshake_fifo #(.WIDTH(42), .DEPTH(3), .AF_THRESH(2)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_b),
        .ack         (ack_b),
        .data_in     (din_b),
        .out_valid   (vld_b),
        .out_ready   (rdy_b),
        .data_out    (dout_b),
        .count       (cnt_b),
        .almost_full (af_b),
        .ovf_sticky  (ovf_b)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nxt;
        int got;
        int cyc;

        // Reset and idle
        rst_n = 1'b0;
        step();
        step();
        chk("rst_count", 64'(cnt_a), 0);
        chk("rst_ack", 64'(ack_a), 1);
        chk("rst_valid", 64'(vld_a), 0);
        chk("rst_af", 64'(af_a), 0);
        chk("rst_ovf", 64'(ovf_a), 0);
        chk("rst_dout", 64'(dout_a), 0);
        chk("rst_count_b", 64'(cnt_b), 0);
        rst_n = 1'b1;
        step();
        chk("idle_count", 64'(cnt_a), 0);

        // Fill to full with the consumer stalled
        req_a = 1'b1;
        din_a = 42'h1; step();
        chk("fill1_count", 64'(cnt_a), 1);
        chk("fill1_af", 64'(af_a), 0);
        chk("fill1_dout", 64'(dout_a), 64'h1);
        chk("fill1_valid", 64'(vld_a), 1);
        din_a = 42'h2; step();
        chk("fill2_count", 64'(cnt_a), 2);
        chk("fill2_af", 64'(af_a), 0);
        din_a = 42'h3; step();
        chk("fill3_count", 64'(cnt_a), 3);
        chk("fill3_af", 64'(af_a), 1);
        chk("fill3_ack", 64'(ack_a), 1);
        din_a = 42'h4; step();
        chk("fill4_count", 64'(cnt_a), 4);
        chk("fill4_ack", 64'(ack_a), 0);
        chk("fill4_ovf", 64'(ovf_a), 0);
        din_a = 42'h5; step();
        chk("ovf_set", 64'(ovf_a), 1);
        chk("ovf_count", 64'(cnt_a), 4);
        chk("ovf_head", 64'(dout_a), 64'h1);

        // Drain from full
        req_a = 1'b0;
        rdy_a = 1'b1;
        step();
        chk("drain_d2", 64'(dout_a), 64'h2);
        chk("drain_c3", 64'(cnt_a), 3);
        step();
        chk("drain_d3", 64'(dout_a), 64'h3);
        step();
        chk("drain_d4", 64'(dout_a), 64'h4);
        chk("drain_c1", 64'(cnt_a), 1);
        step();
        chk("drain_c0", 64'(cnt_a), 0);
        chk("drain_valid", 64'(vld_a), 0);
        chk("drain_ack", 64'(ack_a), 1);
        chk("drain_ovf_kept", 64'(ovf_a), 1);

        // Concurrent push and pop at count 2
        rdy_a = 1'b0;
        req_a = 1'b1;
        din_a = 42'hA; step();
        din_a = 42'hB; step();
        chk("conc_pre_count", 64'(cnt_a), 2);
        chk("conc_pre_head", 64'(dout_a), 64'hA);
        din_a = 42'hC;
        rdy_a = 1'b1;
        step();
        chk("conc_count", 64'(cnt_a), 2);
        chk("conc_head", 64'(dout_a), 64'hB);
        req_a = 1'b0;
        step();
        chk("conc_pop_c", 64'(dout_a), 64'hC);
        chk("conc_pop_cnt", 64'(cnt_a), 1);
        step();
        chk("conc_empty", 64'(cnt_a), 0);
        rdy_a = 1'b0;

        // Wrap-around on the DEPTH=3 instance with irregular gaps
        nxt = 0;
        got = 0;
        cyc = 0;
        while (got < 10 && cyc < 400) begin
            req_b = (nxt < 10) && ($urandom_range(0, 1) == 1);
            din_b = 42'(nxt);
            rdy_b = ($urandom_range(0, 2) != 0);
            #1;
            if (vld_b && rdy_b) begin
                chk("wrap_data", 64'(dout_b), 64'(got));
                got++;
            end
            if (req_b && ack_b) begin
                nxt++;
            end
            step();
            cyc++;
        end
        req_b = 1'b0;
        rdy_b = 1'b0;
        chk("wrap_all_popped", 64'(got), 10);
        chk("wrap_all_pushed", 64'(nxt), 10);
        chk("wrap_count", 64'(cnt_b), 0);

        // Full with push and pop together: only the pop happens
        req_a = 1'b1;
        din_a = 42'h10; step();
        din_a = 42'h11; step();
        din_a = 42'h12; step();
        din_a = 42'h13; step();
        chk("full2_count", 64'(cnt_a), 4);
        din_a = 42'h14;
        rdy_a = 1'b1;
        step();
        chk("fullpp_count", 64'(cnt_a), 3);
        chk("fullpp_head", 64'(dout_a), 64'h11);
        chk("fullpp_ack", 64'(ack_a), 1);
        rdy_a = 1'b0;
        step();
        chk("fullpp_land", 64'(cnt_a), 4);
        req_a = 1'b0;
        rdy_a = 1'b1;
        step();
        step();
        chk("mid_count", 64'(cnt_a), 2);
        chk("mid_head", 64'(dout_a), 64'h13);

        // Reset mid-stream discards contents
        rdy_a = 1'b0;
        rst_n = 1'b0;
        step();
        chk("mrst_count", 64'(cnt_a), 0);
        chk("mrst_valid", 64'(vld_a), 0);
        chk("mrst_dout", 64'(dout_a), 0);
        chk("mrst_ovf", 64'(ovf_a), 0);
        rst_n = 1'b1;
        req_a = 1'b1;
        din_a = 42'h55;
        step();
        req_a = 1'b0;
        chk("post_rst_head", 64'(dout_a), 64'h55);
        chk("post_rst_count", 64'(cnt_a), 1);
        rdy_a = 1'b1;
        step();
        chk("post_rst_empty", 64'(cnt_a), 0);
        chk("post_rst_valid", 64'(vld_a), 0);
        rdy_a = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
